id_operand_sb: RTL and testbench

Parametrised successor to the decode-stage operand logic. Selects rs/rt operands from the register file, immediate, or NUM_FWD prioritised bypass sources. Adds a register scoreboard for long-latency writers (loads, div, madd), load-use/RAW and WAW interlock, and a saturating stall-cycle counter. Sits between regfile/decoder and the ID/EX register; its stallreq feeds ctrl.

---
 rtl/id_operand_sb_pkg.sv | 21 ++
 rtl/id_operand_sb_opsel.sv | 72 +++++++
 rtl/id_operand_sb.sv | 123 ++++++++++++
 tb/tb_id_operand_sb.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_operand_sb_pkg.sv
// Shared constants and types for the decode-stage operand/scoreboard slice.
package id_operand_sb_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned REG_AW_DEF = 5;

   localparam logic [DATA_W_DEF-1:0] ZERO_WORD    = '0;
   localparam logic [REG_AW_DEF-1:0] NOP_REG_ADDR = '0;
   localparam logic                  RST_ENABLE   = 1'b0;
   localparam logic                  READ_ENABLE  = 1'b1;
   localparam logic                  WRITE_ENABLE = 1'b1;

   typedef enum logic [2:0] {
      SRC_IMM,
      SRC_ZERO,
      SRC_FWD,
      SRC_WB,
      SRC_RF
   } op_src_e;

endpackage

// File: rtl/id_operand_sb_opsel.sv
// One operand mux: immediate / r0 / prioritised bypass / writeback / regfile,
// plus the RAW hazard flag for that operand.
module id_operand_sb_opsel
   import id_operand_sb_pkg::*;
#(
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned REG_AW  = REG_AW_DEF,
   parameter int unsigned NUM_FWD = 2
) (
   input  logic                      read_i,
   input  logic [REG_AW-1:0]         addr_i,
   input  logic [DATA_W-1:0]         rf_data_i,
   input  logic [DATA_W-1:0]         imm_i,
   input  logic [NUM_FWD-1:0]        fwd_valid_i,
   input  logic [NUM_FWD-1:0]        fwd_ready_i,
   input  logic [NUM_FWD*REG_AW-1:0] fwd_addr_i,
   input  logic [NUM_FWD*DATA_W-1:0] fwd_data_i,
   input  logic                      wb_done_i,
   input  logic [REG_AW-1:0]         wb_addr_i,
   input  logic [DATA_W-1:0]         wb_data_i,
   input  logic                      pend_eff_i,
   output logic [DATA_W-1:0]         data_o,
   output logic                      hazard_o
);

   op_src_e           src;
   logic              hit;
   logic              hit_ready;
   logic [DATA_W-1:0] hit_data;
   logic              is_zero;

   assign is_zero = (addr_i == REG_AW'(NOP_REG_ADDR));

   // Only the first (youngest) matching channel counts; an unready one
   // shadows every older match.
   always_comb begin
      hit       = 1'b0;
      hit_ready = 1'b0;
      hit_data  = '0;
      for (int unsigned i = 0; i < NUM_FWD; i++) begin
         if (!hit && fwd_valid_i[i] && (fwd_addr_i[i*REG_AW +: REG_AW] == addr_i)) begin
            hit       = 1'b1;
            hit_ready = fwd_ready_i[i];
            hit_data  = fwd_data_i[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      src = SRC_RF;
      if (read_i != READ_ENABLE)                  src = SRC_IMM;
      else if (is_zero)                           src = SRC_ZERO;
      else if (hit)                               src = hit_ready ? SRC_FWD : SRC_RF;
      else if (wb_done_i && wb_addr_i == addr_i)  src = SRC_WB;
   end

   always_comb begin
      data_o = rf_data_i;
      unique case (src)
         SRC_IMM:  data_o = imm_i;
         SRC_ZERO: data_o = DATA_W'(ZERO_WORD);
         SRC_FWD:  data_o = hit_data;
         SRC_WB:   data_o = wb_data_i;
         SRC_RF:   data_o = rf_data_i;
         default:  data_o = rf_data_i;
      endcase
   end

   assign hazard_o = (read_i == READ_ENABLE) && !is_zero &&
                     (hit ? !hit_ready : pend_eff_i);

endmodule

// File: rtl/id_operand_sb.sv
// Decode-stage operand select with long-latency scoreboard, RAW/WAW
// interlock and saturating stall-cycle counter.
module id_operand_sb
   import id_operand_sb_pkg::*;
#(
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned REG_AW  = REG_AW_DEF,
   parameter int unsigned NUM_FWD = 2,
   parameter int unsigned CNT_W   = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      issue_i,
   input  logic                      rs_read_i,
   input  logic                      rt_read_i,
   input  logic [REG_AW-1:0]         rs_addr_i,
   input  logic [REG_AW-1:0]         rt_addr_i,
   input  logic [DATA_W-1:0]         rf_rs_data_i,
   input  logic [DATA_W-1:0]         rf_rt_data_i,
   input  logic [DATA_W-1:0]         imm_i,
   input  logic [NUM_FWD-1:0]        fwd_valid_i,
   input  logic [NUM_FWD-1:0]        fwd_ready_i,
   input  logic [NUM_FWD*REG_AW-1:0] fwd_addr_i,
   input  logic [NUM_FWD*DATA_W-1:0] fwd_data_i,
   input  logic                      long_i,
   input  logic [REG_AW-1:0]         long_wd_i,
   input  logic                      wb_done_i,
   input  logic [REG_AW-1:0]         wb_addr_i,
   input  logic [DATA_W-1:0]         wb_data_i,
   output logic [DATA_W-1:0]         reg1_o,
   output logic [DATA_W-1:0]         reg2_o,
   output logic                      stallreq_o,
   output logic [2**REG_AW-1:0]      sb_pending_o,
   output logic [CNT_W-1:0]          stall_cnt_o
);

   localparam int unsigned NREG = 2**REG_AW;

   logic [NREG-1:0]   pend_q, pend_d, pend_eff, wb_onehot;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] op1, op2;
   logic              haz1, haz2, waw, stall;
   logic              in_rst;

   assign in_rst = (rst == RST_ENABLE);

   always_comb begin
      wb_onehot = '0;
      if (wb_done_i) wb_onehot[wb_addr_i] = 1'b1;
   end

   // A writeback landing this cycle already resolves its register.
   assign pend_eff = pend_q & ~wb_onehot;

   id_operand_sb_opsel #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_opsel_rs (
      .read_i     (rs_read_i),
      .addr_i     (rs_addr_i),
      .rf_data_i  (rf_rs_data_i),
      .imm_i      (imm_i),
      .fwd_valid_i(fwd_valid_i),
      .fwd_ready_i(fwd_ready_i),
      .fwd_addr_i (fwd_addr_i),
      .fwd_data_i (fwd_data_i),
      .wb_done_i  (wb_done_i),
      .wb_addr_i  (wb_addr_i),
      .wb_data_i  (wb_data_i),
      .pend_eff_i (pend_eff[rs_addr_i]),
      .data_o     (op1),
      .hazard_o   (haz1)
   );

   id_operand_sb_opsel #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_opsel_rt (
      .read_i     (rt_read_i),
      .addr_i     (rt_addr_i),
      .rf_data_i  (rf_rt_data_i),
      .imm_i      (imm_i),
      .fwd_valid_i(fwd_valid_i),
      .fwd_ready_i(fwd_ready_i),
      .fwd_addr_i (fwd_addr_i),
      .fwd_data_i (fwd_data_i),
      .wb_done_i  (wb_done_i),
      .wb_addr_i  (wb_addr_i),
      .wb_data_i  (wb_data_i),
      .pend_eff_i (pend_eff[rt_addr_i]),
      .data_o     (op2),
      .hazard_o   (haz2)
   );

   assign waw   = (long_i == WRITE_ENABLE) && (long_wd_i != REG_AW'(NOP_REG_ADDR)) &&
                  pend_eff[long_wd_i];
   assign stall = haz1 | haz2 | waw;

   // Set after clear so a same-register set and clear leaves the bit set.
   always_comb begin
      pend_d = pend_eff;
      if (issue_i && (long_i == WRITE_ENABLE) && !stall &&
          (long_wd_i != REG_AW'(NOP_REG_ADDR)))
         pend_d[long_wd_i] = 1'b1;
      pend_d[0] = 1'b0;
   end

   always_comb begin
      cnt_d = cnt_q;
      if (stall && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ENABLE) begin
         pend_q <= '0;
         cnt_q  <= '0;
      end else begin
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
      end
   end

   assign reg1_o       = in_rst ? DATA_W'(ZERO_WORD) : op1;
   assign reg2_o       = in_rst ? DATA_W'(ZERO_WORD) : op2;
   assign stallreq_o   = !in_rst && stall;
   assign sb_pending_o = pend_q;
   assign stall_cnt_o  = cnt_q;

endmodule

// File: tb/tb_id_operand_sb.sv
// Self-checking bench for id_operand_sb: vector table, directed
// multi-cycle sequences, then randomized traffic against a reference model.
module tb_id_operand_sb;

   logic        clk = 1'b0;
   logic        rst;
   logic        issue, rs_read, rt_read, long_op, wb_done;
   logic [4:0]  rs_addr, rt_addr, long_wd, wb_addr;
   logic [31:0] rf_rs, rf_rt, imm, wb_data;
   logic [1:0]  fwd_valid, fwd_ready;
   logic [9:0]  fwd_addr;
   logic [63:0] fwd_data;
   logic [31:0] reg1, reg2, sb_pending;
   logic        stallreq;
   logic [15:0] stall_cnt;

   int checks = 0;
   int errors = 0;
   int exp_cnt = 0;

   bit          m_pend [32];
   int          m_cnt;

   always #5 clk = ~clk;

   id_operand_sb #(.DATA_W(32), .REG_AW(5), .NUM_FWD(2), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .issue_i(issue),
      .rs_read_i(rs_read), .rt_read_i(rt_read),
      .rs_addr_i(rs_addr), .rt_addr_i(rt_addr),
      .rf_rs_data_i(rf_rs), .rf_rt_data_i(rf_rt), .imm_i(imm),
      .fwd_valid_i(fwd_valid), .fwd_ready_i(fwd_ready),
      .fwd_addr_i(fwd_addr), .fwd_data_i(fwd_data),
      .long_i(long_op), .long_wd_i(long_wd),
      .wb_done_i(wb_done), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
      .reg1_o(reg1), .reg2_o(reg2), .stallreq_o(stallreq),
      .sb_pending_o(sb_pending), .stall_cnt_o(stall_cnt)
   );

   typedef struct {
      logic        rs_rd;  logic [4:0] rs_a;
      logic        rt_rd;  logic [4:0] rt_a;
      logic [1:0]  fv;     logic [1:0] fr;
      logic [4:0]  fa0;    logic [4:0] fa1;
      logic [31:0] fd0;    logic [31:0] fd1;
      logic        wb;     logic [4:0] wa;    logic [31:0] wd;
      logic [31:0] e1;     logic [31:0] e2;   logic es;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      issue = 0; rs_read = 0; rt_read = 0; long_op = 0; wb_done = 0;
      rs_addr = 0; rt_addr = 0; long_wd = 0; wb_addr = 0;
      rf_rs = 32'h1111_1111; rf_rt = 32'h2222_2222; imm = 32'h0000_00EE;
      wb_data = 0; fwd_valid = 0; fwd_ready = 0; fwd_addr = 0; fwd_data = 0;
   endtask

   // Reference operand rule, evaluated from the current inputs and model state.
   function automatic void m_op(input logic rd, input logic [4:0] a, input logic [31:0] rf,
                                output logic [31:0] v, output logic hz);
      int  first;
      bit  pe;
      first = -1;
      v = rf;
      hz = 0;
      if (!rd) begin v = imm; return; end
      if (a == 0) begin v = 0; return; end
      for (int c = 0; c < 2; c++)
         if (first < 0 && fwd_valid[c] && fwd_addr[c*5 +: 5] == a) first = c;
      pe = m_pend[a] && !(wb_done && wb_addr == a);
      if (first >= 0) begin
         if (fwd_ready[first]) v = fwd_data[first*32 +: 32];
         else hz = 1;
      end else if (wb_done && wb_addr == a) v = wb_data;
      if (pe && !(first >= 0 && fwd_ready[first])) hz = 1;
   endfunction

   initial begin
      logic [31:0] e1, e2, pv;
      logic        h1, h2, waw, st;

      idle();
      rst = 0;
      rs_read = 1; rs_addr = 3;
      tick(); tick();
      chk("rst_pending", sb_pending, 0);
      chk("rst_cnt", stall_cnt, 0);
      chk("rst_stall", stallreq, 0);
      chk("rst_reg1", reg1, 0);
      rst = 1;
      idle();
      tick();

      //            rs_rd rs  rt_rd rt  fv     fr     fa0 fa1 fd0            fd1            wb wa wd     e1             e2             es
      tbl[0] = '{1, 3, 0, 0, 2'b11, 2'b11, 3, 3, 32'hAAAA, 32'hBBBB, 0, 0, 0, 32'hAAAA, 32'hEE, 0};
      tbl[1] = '{1, 3, 0, 0, 2'b10, 2'b11, 3, 3, 32'hAAAA, 32'hBBBB, 0, 0, 0, 32'hBBBB, 32'hEE, 0};
      tbl[2] = '{1, 3, 0, 0, 2'b11, 2'b10, 3, 3, 32'hAAAA, 32'hBBBB, 0, 0, 0, 32'h1111_1111, 32'hEE, 1};
      tbl[3] = '{1, 3, 0, 0, 2'b11, 2'b01, 5, 3, 32'hAAAA, 32'hBBBB, 0, 0, 0, 32'h1111_1111, 32'hEE, 1};
      tbl[4] = '{1, 3, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 3, 32'h77, 32'h77, 32'hEE, 0};
      tbl[5] = '{1, 3, 0, 0, 2'b10, 2'b10, 0, 3, 0, 32'hBBBB, 1, 3, 32'h77, 32'hBBBB, 32'hEE, 0};
      tbl[6] = '{1, 0, 1, 0, 2'b01, 2'b01, 0, 0, 32'hFFFF, 0, 0, 0, 0, 0, 0, 0};
      tbl[7] = '{0, 0, 1, 6, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'hEE, 32'h2222_2222, 0};
      tbl[8] = '{0, 0, 1, 4, 2'b01, 2'b00, 4, 0, 32'h9999, 0, 0, 0, 0, 32'hEE, 32'h2222_2222, 1};
      tbl[9] = '{1, 7, 1, 7, 2'b11, 2'b10, 2, 7, 32'h5, 32'hCAFE, 0, 0, 0, 32'hCAFE, 32'hCAFE, 0};

      for (int i = 0; i < 10; i++) begin
         idle();
         rs_read = tbl[i].rs_rd; rs_addr = tbl[i].rs_a;
         rt_read = tbl[i].rt_rd; rt_addr = tbl[i].rt_a;
         fwd_valid = tbl[i].fv; fwd_ready = tbl[i].fr;
         fwd_addr = {tbl[i].fa1, tbl[i].fa0};
         fwd_data = {tbl[i].fd1, tbl[i].fd0};
         wb_done = tbl[i].wb; wb_addr = tbl[i].wa; wb_data = tbl[i].wd;
         #2;
         chk($sformatf("vec%0d_reg1", i), reg1, tbl[i].e1);
         chk($sformatf("vec%0d_reg2", i), reg2, tbl[i].e2);
         chk($sformatf("vec%0d_stall", i), stallreq, tbl[i].es);
         chk($sformatf("vec%0d_cnt", i), stall_cnt, exp_cnt);
         if (tbl[i].es) exp_cnt++;
         tick();
      end

      // Load-use: unready youngest bypass, then ready.
      idle();
      rt_read = 1; rt_addr = 4; fwd_valid = 2'b01; fwd_addr = {5'd0, 5'd4};
      for (int k = 0; k < 2; k++) begin
         #2;
         chk("lu_stall", stallreq, 1);
         chk("lu_cnt", stall_cnt, exp_cnt);
         exp_cnt++;
         tick();
      end
      fwd_ready = 2'b01; fwd_data = {32'h0, 32'h1234};
      #2;
      chk("lu_reg2", reg2, 32'h1234);
      chk("lu_stall_clr", stallreq, 0);
      chk("lu_cnt_hold", stall_cnt, exp_cnt);
      tick();

      // Long-latency div to r8, RAW on it, writeback resolves same cycle.
      idle();
      issue = 1; long_op = 1; long_wd = 8;
      #2 chk("div_issue_stall", stallreq, 0);
      tick();
      idle();
      rs_read = 1; rs_addr = 8;
      #2;
      chk("div_pending", sb_pending, 32'h100);
      chk("div_raw_stall", stallreq, 1);
      exp_cnt++;
      tick();
      wb_done = 1; wb_addr = 8; wb_data = 32'h55;
      #2;
      chk("div_wb_reg1", reg1, 32'h55);
      chk("div_wb_stall", stallreq, 0);
      chk("div_wb_pend_hold", sb_pending, 32'h100);
      tick();
      idle();
      #2 chk("div_cleared", sb_pending, 0);

      // WAW on r9; same-cycle clear and re-set keeps the bit.
      issue = 1; long_op = 1; long_wd = 9;
      tick();
      issue = 0;
      #2 chk("waw_stall", stallreq, 1);
      exp_cnt++;
      tick();
      issue = 1; wb_done = 1; wb_addr = 9; wb_data = 32'h9;
      #2 chk("waw_wb_nostall", stallreq, 0);
      tick();
      idle();
      #2 chk("waw_bit_set", sb_pending, 32'h200);
      wb_done = 1; wb_addr = 9;
      tick();
      idle();
      #2 chk("waw_bit_clr", sb_pending, 0);

      // r0 is never forwarded nor tracked.
      rs_read = 1; rs_addr = 0; fwd_valid = 2'b01; fwd_ready = 2'b01;
      fwd_addr = {5'd0, 5'd0}; fwd_data = {32'h0, 32'hFFFF};
      issue = 1; long_op = 1; long_wd = 0;
      #2;
      chk("r0_reg1", reg1, 0);
      chk("r0_stall", stallreq, 0);
      tick();
      idle();
      #2 chk("r0_pending", sb_pending, 0);

      // Mid-run reset with r5 pending and a nonzero counter.
      issue = 1; long_op = 1; long_wd = 5;
      tick();
      idle();
      rs_read = 1; rs_addr = 5;
      while (exp_cnt < 9) begin
         exp_cnt++;
         tick();
      end
      #2;
      chk("pre_rst_cnt", stall_cnt, exp_cnt);
      chk("pre_rst_pend", sb_pending, 32'h20);
      rst = 0;
      #1;
      chk("mid_rst_pend", sb_pending, 0);
      chk("mid_rst_cnt", stall_cnt, 0);
      chk("mid_rst_stall", stallreq, 0);
      chk("mid_rst_reg1", reg1, 0);
      tick();
      rst = 1;
      idle();
      tick();

      // Randomized traffic against the reference model.
      foreach (m_pend[r]) m_pend[r] = 0;
      m_cnt = 0;
      for (int n = 0; n < 400; n++) begin
         issue     = 1'($urandom_range(0, 1));
         rs_read   = ($urandom_range(0, 3) != 0);
         rt_read   = ($urandom_range(0, 3) != 0);
         rs_addr   = 5'($urandom_range(0, 7));
         rt_addr   = 5'($urandom_range(0, 7));
         rf_rs     = $urandom;
         rf_rt     = $urandom;
         imm       = $urandom;
         fwd_valid = 2'($urandom_range(0, 3));
         fwd_ready = 2'($urandom_range(0, 3));
         fwd_addr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         fwd_data  = {$urandom, $urandom};
         long_op   = ($urandom_range(0, 2) == 0);
         long_wd   = 5'($urandom_range(0, 7));
         wb_done   = ($urandom_range(0, 2) == 0);
         wb_addr   = 5'($urandom_range(0, 7));
         wb_data   = $urandom;
         #2;
         m_op(rs_read, rs_addr, rf_rs, e1, h1);
         m_op(rt_read, rt_addr, rf_rt, e2, h2);
         waw = long_op && long_wd != 0 && m_pend[long_wd] && !(wb_done && wb_addr == long_wd);
         st = h1 | h2 | waw;
         pv = 0;
         for (int r = 0; r < 32; r++) pv[r] = m_pend[r];
         chk("rnd_reg1", reg1, e1);
         chk("rnd_reg2", reg2, e2);
         chk("rnd_stall", stallreq, st);
         chk("rnd_pending", sb_pending, pv);
         chk("rnd_cnt", stall_cnt, m_cnt);
         if (wb_done) m_pend[wb_addr] = 0;
         if (issue && long_op && !st && long_wd != 0) m_pend[long_wd] = 1;
         if (st && m_cnt < 65535) m_cnt++;
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
